// File: rtl/id_operand_fetch_pkg.sv
// Shared CPU constants and the ID/EX pipeline register layout for the decode operand front end.
package id_operand_fetch_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic EN           = 1'b1;
  localparam logic DIS          = 1'b0;
  localparam logic RESET_ACTIVE = 1'b1;

  typedef struct packed {
    logic                  en;
    logic [DATA_W-1:0]     ra_data;
    logic [DATA_W-1:0]     rb_data;
    logic [REG_ADDR_W-1:0] dst_addr;
    logic                  dst_we;
    logic                  is_load;
  } id_ex_t;

endpackage

// File: rtl/id_operand_fetch_fwd_mux.sv
// Per-source operand resolution: the younger EX result wins over MEM, which wins over the GPR read.
module id_operand_fetch_fwd_mux
  import id_operand_fetch_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic                  ex_en,
  input  logic [REG_ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0]     ex_data,
  input  logic                  mem_en,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic [DATA_W-1:0]     gpr_data,
  output logic [DATA_W-1:0]     data
);

  always_comb begin
    data = gpr_data;
    if (ex_en == EN && ex_addr == src_addr) begin
      data = ex_data;
    end else if (mem_en == EN && mem_addr == src_addr) begin
      data = mem_data;
    end
  end

endmodule

// File: rtl/id_operand_fetch.sv
// Decode-stage operand fetch: GPR addressing, EX/MEM forwarding, load-use bubbles and the ID/EX register.
module id_operand_fetch
  import id_operand_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_en,
  input  logic [REG_ADDR_W-1:0] if_ra_addr,
  input  logic [REG_ADDR_W-1:0] if_rb_addr,
  input  logic                  if_rb_used,
  input  logic [REG_ADDR_W-1:0] if_dst_addr,
  input  logic                  if_dst_we,
  input  logic                  if_is_load,
  input  logic                  stall,
  input  logic                  flush,
  output logic [REG_ADDR_W-1:0] gpr_rd_addr_0,
  output logic [REG_ADDR_W-1:0] gpr_rd_addr_1,
  input  logic [DATA_W-1:0]     gpr_rd_data_0,
  input  logic [DATA_W-1:0]     gpr_rd_data_1,
  input  logic                  ex_fwd_en,
  input  logic [REG_ADDR_W-1:0] ex_fwd_addr,
  input  logic [DATA_W-1:0]     ex_fwd_data,
  input  logic                  mem_fwd_en,
  input  logic [REG_ADDR_W-1:0] mem_fwd_addr,
  input  logic [DATA_W-1:0]     mem_fwd_data,
  output logic                  ld_hazard,
  output logic                  id_en,
  output logic [DATA_W-1:0]     id_ra_data,
  output logic [DATA_W-1:0]     id_rb_data,
  output logic [REG_ADDR_W-1:0] id_dst_addr,
  output logic                  id_dst_we,
  output logic                  id_is_load
);

  id_ex_t            id_q;
  id_ex_t            id_d;
  logic [DATA_W-1:0] ra_resolved;
  logic [DATA_W-1:0] rb_resolved;
  logic              src_match;

  assign gpr_rd_addr_0 = if_ra_addr;
  assign gpr_rd_addr_1 = if_rb_addr;

  id_operand_fetch_fwd_mux u_fwd_a (
    .src_addr (if_ra_addr),
    .ex_en    (ex_fwd_en),
    .ex_addr  (ex_fwd_addr),
    .ex_data  (ex_fwd_data),
    .mem_en   (mem_fwd_en),
    .mem_addr (mem_fwd_addr),
    .mem_data (mem_fwd_data),
    .gpr_data (gpr_rd_data_0),
    .data     (ra_resolved)
  );

  id_operand_fetch_fwd_mux u_fwd_b (
    .src_addr (if_rb_addr),
    .ex_en    (ex_fwd_en),
    .ex_addr  (ex_fwd_addr),
    .ex_data  (ex_fwd_data),
    .mem_en   (mem_fwd_en),
    .mem_addr (mem_fwd_addr),
    .mem_data (mem_fwd_data),
    .gpr_data (gpr_rd_data_1),
    .data     (rb_resolved)
  );

  // A load in ID/EX cannot forward its data yet; a stalled pipe holds everything so no bubble is needed.
  assign src_match = (id_q.dst_addr == if_ra_addr) ||
                     (if_rb_used && (id_q.dst_addr == if_rb_addr));
  assign ld_hazard = !stall && if_en && id_q.en && id_q.is_load && id_q.dst_we && src_match;

  always_comb begin
    id_d = id_q;
    if (flush == EN) begin
      id_d = '0;
    end else if (stall == EN) begin
      id_d = id_q;
    end else if (ld_hazard) begin
      id_d.en      = DIS;
      id_d.dst_we  = DIS;
      id_d.is_load = DIS;
    end else begin
      id_d.en       = if_en;
      id_d.ra_data  = ra_resolved;
      id_d.rb_data  = rb_resolved;
      id_d.dst_addr = if_dst_addr;
      id_d.dst_we   = if_en && if_dst_we;
      id_d.is_load  = if_en && if_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (reset == RESET_ACTIVE) begin
      id_q <= '0;
    end else begin
      id_q <= id_d;
    end
  end

  assign id_en       = id_q.en;
  assign id_ra_data  = id_q.ra_data;
  assign id_rb_data  = id_q.rb_data;
  assign id_dst_addr = id_q.dst_addr;
  assign id_dst_we   = id_q.dst_we;
  assign id_is_load  = id_q.is_load;

endmodule

// File: tb/tb_id_operand_fetch.sv
// Directed bench for id_operand_fetch: reset, forwarding priority, load-use bubble, stall/flush and mid-run reset.
module tb_id_operand_fetch;

  logic        clk;
  logic        reset;
  logic        if_en;
  logic [4:0]  if_ra_addr;
  logic [4:0]  if_rb_addr;
  logic        if_rb_used;
  logic [4:0]  if_dst_addr;
  logic        if_dst_we;
  logic        if_is_load;
  logic        stall;
  logic        flush;
  logic [4:0]  gpr_rd_addr_0;
  logic [4:0]  gpr_rd_addr_1;
  logic [31:0] gpr_rd_data_0;
  logic [31:0] gpr_rd_data_1;
  logic        ex_fwd_en;
  logic [4:0]  ex_fwd_addr;
  logic [31:0] ex_fwd_data;
  logic        mem_fwd_en;
  logic [4:0]  mem_fwd_addr;
  logic [31:0] mem_fwd_data;
  logic        ld_hazard;
  logic        id_en;
  logic [31:0] id_ra_data;
  logic [31:0] id_rb_data;
  logic [4:0]  id_dst_addr;
  logic        id_dst_we;
  logic        id_is_load;

  int passCount  = 0;
  int checkCount = 0;

  id_operand_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .if_en         (if_en),
    .if_ra_addr    (if_ra_addr),
    .if_rb_addr    (if_rb_addr),
    .if_rb_used    (if_rb_used),
    .if_dst_addr   (if_dst_addr),
    .if_dst_we     (if_dst_we),
    .if_is_load    (if_is_load),
    .stall         (stall),
    .flush         (flush),
    .gpr_rd_addr_0 (gpr_rd_addr_0),
    .gpr_rd_addr_1 (gpr_rd_addr_1),
    .gpr_rd_data_0 (gpr_rd_data_0),
    .gpr_rd_data_1 (gpr_rd_data_1),
    .ex_fwd_en     (ex_fwd_en),
    .ex_fwd_addr   (ex_fwd_addr),
    .ex_fwd_data   (ex_fwd_data),
    .mem_fwd_en    (mem_fwd_en),
    .mem_fwd_addr  (mem_fwd_addr),
    .mem_fwd_data  (mem_fwd_data),
    .ld_hazard     (ld_hazard),
    .id_en         (id_en),
    .id_ra_data    (id_ra_data),
    .id_rb_data    (id_rb_data),
    .id_dst_addr   (id_dst_addr),
    .id_dst_we     (id_dst_we),
    .id_is_load    (id_is_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      $error("[TB] %s observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearFwd();
    ex_fwd_en    = 1'b0;
    ex_fwd_addr  = 5'd0;
    ex_fwd_data  = 32'h0;
    mem_fwd_en   = 1'b0;
    mem_fwd_addr = 5'd0;
    mem_fwd_data = 32'h0;
  endtask

  initial begin
    reset         = 1'b1;
    if_en         = 1'b1;
    if_ra_addr    = 5'd1;
    if_rb_addr    = 5'd2;
    if_rb_used    = 1'b1;
    if_dst_addr   = 5'd9;
    if_dst_we     = 1'b1;
    if_is_load    = 1'b1;
    stall         = 1'b0;
    flush         = 1'b0;
    gpr_rd_data_0 = 32'hFFFF_0000;
    gpr_rd_data_1 = 32'h0000_FFFF;
    clearFwd();

    // Reset held two cycles with a valid instruction presented
    applyStimulus(2);
    checkOutput("reset_id_en", {31'b0, id_en}, 32'h0);
    checkOutput("reset_ra", id_ra_data, 32'h0);
    checkOutput("reset_rb", id_rb_data, 32'h0);
    checkOutput("reset_dst", {27'b0, id_dst_addr}, 32'h0);
    checkOutput("reset_we", {31'b0, id_dst_we}, 32'h0);
    checkOutput("reset_load", {31'b0, id_is_load}, 32'h0);
    reset = 1'b0;

    // Plain GPR read, no forwarding
    if_ra_addr    = 5'd3;
    if_rb_addr    = 5'd4;
    if_dst_addr   = 5'd7;
    if_is_load    = 1'b0;
    gpr_rd_data_0 = 32'h11;
    gpr_rd_data_1 = 32'h44;
    #1;
    checkOutput("gpr_addr0", {27'b0, gpr_rd_addr_0}, 32'd3);
    checkOutput("gpr_addr1", {27'b0, gpr_rd_addr_1}, 32'd4);
    applyStimulus(1);
    checkOutput("nofwd_id_en", {31'b0, id_en}, 32'h1);
    checkOutput("nofwd_ra", id_ra_data, 32'h11);
    checkOutput("nofwd_rb", id_rb_data, 32'h44);
    checkOutput("nofwd_dst", {27'b0, id_dst_addr}, 32'd7);
    checkOutput("nofwd_we", {31'b0, id_dst_we}, 32'h1);

    // EX and MEM both target r3: EX wins; B (r4) untouched
    ex_fwd_en    = 1'b1;
    ex_fwd_addr  = 5'd3;
    ex_fwd_data  = 32'hAA;
    mem_fwd_en   = 1'b1;
    mem_fwd_addr = 5'd3;
    mem_fwd_data = 32'hBB;
    applyStimulus(1);
    checkOutput("prio_ex_ra", id_ra_data, 32'hAA);
    checkOutput("prio_rb_gpr", id_rb_data, 32'h44);

    // Only MEM matches
    ex_fwd_en = 1'b0;
    applyStimulus(1);
    checkOutput("mem_only_ra", id_ra_data, 32'hBB);

    // EX enabled but to a different register falls through to MEM on B
    ex_fwd_en    = 1'b1;
    ex_fwd_addr  = 5'd8;
    mem_fwd_addr = 5'd4;
    mem_fwd_data = 32'hCC;
    applyStimulus(1);
    checkOutput("mem_rb", id_rb_data, 32'hCC);
    checkOutput("gpr_ra_fallthru", id_ra_data, 32'h11);
    clearFwd();

    // Load to r5 enters ID/EX
    if_ra_addr  = 5'd1;
    if_rb_addr  = 5'd2;
    if_dst_addr = 5'd5;
    if_is_load  = 1'b1;
    applyStimulus(1);
    checkOutput("load_in_id", {31'b0, id_is_load}, 32'h1);

    // Dependent on B: one bubble, then MEM forward supplies the load data
    if_ra_addr    = 5'd2;
    if_rb_addr    = 5'd5;
    if_rb_used    = 1'b1;
    if_dst_addr   = 5'd6;
    if_is_load    = 1'b0;
    gpr_rd_data_1 = 32'hDEAD;
    #1;
    checkOutput("ldh_raised", {31'b0, ld_hazard}, 32'h1);
    applyStimulus(1);
    checkOutput("bubble_id_en", {31'b0, id_en}, 32'h0);
    checkOutput("bubble_we", {31'b0, id_dst_we}, 32'h0);
    checkOutput("bubble_load", {31'b0, id_is_load}, 32'h0);
    checkOutput("ldh_cleared", {31'b0, ld_hazard}, 32'h0);
    mem_fwd_en   = 1'b1;
    mem_fwd_addr = 5'd5;
    mem_fwd_data = 32'h1234;
    applyStimulus(1);
    checkOutput("after_bubble_en", {31'b0, id_en}, 32'h1);
    checkOutput("after_bubble_rb", id_rb_data, 32'h1234);
    checkOutput("after_bubble_dst", {27'b0, id_dst_addr}, 32'd6);
    clearFwd();

    // Same dependency with B unused: no hazard, no bubble
    if_ra_addr  = 5'd1;
    if_rb_addr  = 5'd2;
    if_dst_addr = 5'd5;
    if_is_load  = 1'b1;
    applyStimulus(1);
    if_ra_addr  = 5'd2;
    if_rb_addr  = 5'd5;
    if_rb_used  = 1'b0;
    if_dst_addr = 5'd6;
    if_is_load  = 1'b0;
    #1;
    checkOutput("rb_unused_ldh", {31'b0, ld_hazard}, 32'h0);
    applyStimulus(1);
    checkOutput("rb_unused_en", {31'b0, id_en}, 32'h1);

    // Dependency on A triggers a hazard regardless of B usage
    if_ra_addr    = 5'd1;
    if_dst_addr   = 5'd5;
    if_is_load    = 1'b1;
    gpr_rd_data_0 = 32'h55;
    applyStimulus(1);
    if_ra_addr = 5'd5;
    if_is_load = 1'b0;
    #1;
    checkOutput("ra_dep_ldh", {31'b0, ld_hazard}, 32'h1);

    // Stall gates the hazard and holds ID/EX for three cycles
    stall         = 1'b1;
    gpr_rd_data_0 = 32'h99;
    #1;
    checkOutput("stall_gates_ldh", {31'b0, ld_hazard}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput("stall_hold_en", {31'b0, id_en}, 32'h1);
      checkOutput("stall_hold_ra", id_ra_data, 32'h55);
      checkOutput("stall_hold_load", {31'b0, id_is_load}, 32'h1);
    end

    // Flush wins over stall
    flush = 1'b1;
    applyStimulus(1);
    checkOutput("flush_en", {31'b0, id_en}, 32'h0);
    checkOutput("flush_ra", id_ra_data, 32'h0);
    checkOutput("flush_load", {31'b0, id_is_load}, 32'h0);
    flush = 1'b0;
    stall = 1'b0;

    // Idle slot: if_en=0 clears write/load flags
    if_en     = 1'b0;
    if_dst_we = 1'b1;
    applyStimulus(1);
    checkOutput("idle_we", {31'b0, id_dst_we}, 32'h0);
    if_en = 1'b1;
    applyStimulus(1);
    checkOutput("refill_en", {31'b0, id_en}, 32'h1);

    // Reset mid-operation overrides stall
    stall = 1'b1;
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("midreset_en", {31'b0, id_en}, 32'h0);
    checkOutput("midreset_ra", id_ra_data, 32'h0);
    reset = 1'b0;
    stall = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/id_operand_fetch.md
Name: id_operand_fetch

Overview:
- Decode-stage operand front end. Sits between the IF/ID boundary and the EX stage, directly upstream of EX and beside the two-read/one-write general purpose register file.
- Drives both GPR read addresses from the incoming instruction fields. Resolves RAW hazards by forwarding from EX and MEM.
- Detects load-use hazards and inserts a bubble.
- Registers the resolved operands into the ID/EX pipeline register.

Parameters:
DATA_W, 32, operand/word width
REG_ADDR_W, 5, register address width (32 registers; r0 is an ordinary register, not hardwired zero)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
if_en  in  1  IF/ID holds a valid instruction
if_ra_addr  in  REG_ADDR_W  source A register
if_rb_addr  in  REG_ADDR_W  source B register
if_rb_used  in  1  instruction reads source B
if_dst_addr  in  REG_ADDR_W  destination register
if_dst_we  in  1  instruction writes destination
if_is_load  in  1  instruction is a memory load
stall  in  1  downstream stall; hold ID/EX
flush  in  1  kill ID/EX contents (branch/exception)
gpr_rd_addr_0  out  REG_ADDR_W  GPR port 0 address (= if_ra_addr, combinational)
gpr_rd_addr_1  out  REG_ADDR_W  GPR port 1 address (= if_rb_addr, combinational)
gpr_rd_data_0  in  DATA_W  GPR port 0 data (already write-bypassed by GPR)
gpr_rd_data_1  in  DATA_W  GPR port 1 data
ex_fwd_en  in  1  EX result valid and will be written
ex_fwd_addr  in  REG_ADDR_W  EX destination
ex_fwd_data  in  DATA_W  EX result
mem_fwd_en  in  1  MEM result valid and will be written
mem_fwd_addr  in  REG_ADDR_W  MEM destination
mem_fwd_data  in  DATA_W  MEM result
ld_hazard  out  1  load-use hazard; IF/ID must hold (combinational)
id_en  out  1  ID/EX valid
id_ra_data  out  DATA_W  resolved operand A
id_rb_data  out  DATA_W  resolved operand B
id_dst_addr  out  REG_ADDR_W  registered destination
id_dst_we  out  1  registered write enable
id_is_load  out  1  registered load flag

Behaviour:
- Operand resolution is combinational, per source. Priority:
  - ex_fwd_en && ex_fwd_addr==src selects ex_fwd_data;
  - else mem_fwd_en && mem_fwd_addr==src selects mem_fwd_data;
  - else GPR data.
  - EX beats MEM when both match (younger result wins).
- ld_hazard = if_en && id_en && id_is_load && id_dst_we && ((id_dst_addr==if_ra_addr) || (if_rb_used && id_dst_addr==if_rb_addr)).
  - Source B is ignored when if_rb_used=0.
  - ld_hazard is gated low while stall=1.
- ID/EX register update priority per posedge: reset > flush > stall > ld_hazard > normal.
  - reset: all outputs 0 (id_en=0, data 0, dst 0, we 0, load 0).
  - flush: id_en=0, id_dst_we=0, id_is_load=0; data/dst cleared to 0. Flush overrides stall and hazard.
  - stall: all id_* hold their values.
  - ld_hazard: bubble. id_en=0, id_dst_we=0, id_is_load=0. IF/ID holds, so the same instruction re-presents next cycle and forwards from MEM (the load result arrives via mem_fwd).
  - normal: id_en<=if_en; the other fields load resolved operands and IF fields. When if_en=0, id_dst_we and id_is_load load 0.
- Latency: one cycle from IF/ID fields to id_*. Exactly one bubble cycle per load-use hazard.
- Reset asserted mid-operation clears ID/EX on the next edge regardless of stall/flush.

Decomposition:
- Shared cpu package/header: DATA_W, REG_ADDR_W, enable/disable and reset-level constants.
- One natural sub-module, fwd_mux: one source address plus three data candidates in, resolved data out. Instantiate it twice.

Test Plan:
- Reset: hold reset 2 cycles with if_en=1 -> all id_* =0, id_en=0.
- No forwarding: r3=0x11 in GPR, if_ra=3, fwd disabled -> id_ra_data=0x11, id_en=1 one cycle later.
- Priority: ex_fwd(r3,0xAA) and mem_fwd(r3,0xBB) together, if_ra=3 -> id_ra_data=0xAA. Only mem_fwd -> 0xBB.
- Load-use: ID holds load to r5; next instr if_rb=5 with if_rb_used=1 -> ld_hazard=1, next id_en=0. Following cycle with mem_fwd(r5,0x1234) -> id_rb_data=0x1234.
- Same case with if_rb_used=0 -> ld_hazard=0, no bubble.
- stall=1 for 3 cycles -> id_* constant. flush during stall -> id_en=0 next edge.
